fb_bram_arbiter: RTL and testbench

- Shares the single-port frame-buffer BRAM between two requesters: the display refresh path, which reads one pixel per request and must never stall, and a host/camera writer that supplies pixels over a valid/ready handshake.
- Display reads have absolute priority.
- Writes are buffered in a small FIFO and drained into idle BRAM cycles, optionally only during vertical blanking for tear-free update.
- Sits between the display timing/address generator and the BRAM primitive, in the TCLK domain.

---
 rtl/fb_bram_arbiter.sv | 156 +++++++++++++++
 tb/tb_fb_bram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_bram_arbiter
// Purpose  : Shares one single-port frame-buffer BRAM between a never-stalling
//            display read path and a FIFO-buffered pixel writer.
// Revision : 1.0  initial release
// ============================================================================
module fb_bram_arbiter #(
    parameter int AW           = 17,
    parameter int DW           = 24,
    parameter int WF_DEPTH     = 4,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                       CLK,
    input  logic                       nRESET,
    input  logic                       disp_rd_req,
    input  logic [AW-1:0]              disp_rd_addr,
    output logic                       disp_rd_valid,
    output logic [DW-1:0]              disp_rd_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DW-1:0]              wr_data,
    input  logic                       vblank,
    input  logic                       wr_vblank_only,
    input  logic                       clr_status,
    output logic [$clog2(WF_DEPTH):0]  wr_count,
    output logic                       wr_starve,
    output logic                       bram_en,
    output logic                       bram_we,
    output logic [AW-1:0]              bram_addr,
    output logic [DW-1:0]              bram_din,
    input  logic [DW-1:0]              bram_dout
);

    localparam int PW = $clog2(WF_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(WF_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [AW-1:0] fifo_addr_q [WF_DEPTH];
    logic [DW-1:0] fifo_data_q [WF_DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ready_q, wr_ready_d;
    logic          push, pop;

    logic          bram_en_q, bram_en_d;
    logic          bram_we_q, bram_we_d;
    logic [AW-1:0] bram_addr_q, bram_addr_d;
    logic [DW-1:0] bram_din_q, bram_din_d;

    logic          rd_p1_q, rd_p1_d;
    logic          disp_rd_valid_q, disp_rd_valid_d;
    logic [DW-1:0] disp_rd_data_q, disp_rd_data_d;

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          wr_starve_q, wr_starve_d;

    // Display reads always win the slot; writes only fill otherwise idle cycles.
    always_comb begin
        push = wr_valid && wr_ready_q;
        pop  = !disp_rd_req && (count_q != '0) && (!wr_vblank_only || vblank);

        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ready_d = (count_d < FULL_CNT);

        bram_en_d   = disp_rd_req || pop;
        bram_we_d   = pop;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        if (disp_rd_req) begin
            bram_addr_d = disp_rd_addr;
        end else if (pop) begin
            bram_addr_d = fifo_addr_q[rd_ptr_q];
            bram_din_d  = fifo_data_q[rd_ptr_q];
        end

        // Read command goes out one edge after the request, data returns one edge later.
        rd_p1_d         = bram_en_q && !bram_we_q;
        disp_rd_valid_d = rd_p1_q;
        disp_rd_data_d  = rd_p1_q ? bram_dout : disp_rd_data_q;

        starve_cnt_d = starve_cnt_q;
        wr_starve_d  = wr_starve_q;
        if (clr_status) begin
            starve_cnt_d = '0;
            wr_starve_d  = 1'b0;
        end else if ((count_q == FULL_CNT) && !pop) begin
            if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
            if (starve_cnt_d == STARVE_MAX) begin
                wr_starve_d = 1'b1;
            end
        end else begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            wr_ready_q      <= 1'b0;
            bram_en_q       <= 1'b0;
            bram_we_q       <= 1'b0;
            bram_addr_q     <= '0;
            bram_din_q      <= '0;
            rd_p1_q         <= 1'b0;
            disp_rd_valid_q <= 1'b0;
            disp_rd_data_q  <= '0;
            starve_cnt_q    <= '0;
            wr_starve_q     <= 1'b0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            wr_ready_q      <= wr_ready_d;
            bram_en_q       <= bram_en_d;
            bram_we_q       <= bram_we_d;
            bram_addr_q     <= bram_addr_d;
            bram_din_q      <= bram_din_d;
            rd_p1_q         <= rd_p1_d;
            disp_rd_valid_q <= disp_rd_valid_d;
            disp_rd_data_q  <= disp_rd_data_d;
            starve_cnt_q    <= starve_cnt_d;
            wr_starve_q     <= wr_starve_d;
        end
    end

    assign wr_ready      = wr_ready_q;
    assign wr_count      = count_q;
    assign wr_starve     = wr_starve_q;
    assign bram_en       = bram_en_q;
    assign bram_we       = bram_we_q;
    assign bram_addr     = bram_addr_q;
    assign bram_din      = bram_din_q;
    assign disp_rd_valid = disp_rd_valid_q;
    assign disp_rd_data  = disp_rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_bram_arbiter
// Purpose  : Directed plus randomized bench for fb_bram_arbiter against a
//            queue-based transaction model and a behavioural BRAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_bram_arbiter;

    localparam int TAW    = 10;
    localparam int TDW    = 24;
    localparam int TDEPTH = 4;
    localparam int TLIM   = 8;
    localparam int NMEM   = 1 << TAW;

    logic             CLK;
    logic             nRESET;
    logic             disp_rd_req;
    logic [TAW-1:0]   disp_rd_addr;
    logic             disp_rd_valid;
    logic [TDW-1:0]   disp_rd_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [TAW-1:0]   wr_addr;
    logic [TDW-1:0]   wr_data;
    logic             vblank;
    logic             wr_vblank_only;
    logic             clr_status;
    logic [2:0]       wr_count;
    logic             wr_starve;
    logic             bram_en;
    logic             bram_we;
    logic [TAW-1:0]   bram_addr;
    logic [TDW-1:0]   bram_din;
    logic [TDW-1:0]   bram_dout;

    fb_bram_arbiter #(
        .AW(TAW), .DW(TDW), .WF_DEPTH(TDEPTH), .STARVE_LIMIT(TLIM)
    ) dut (
        .CLK(CLK), .nRESET(nRESET),
        .disp_rd_req(disp_rd_req), .disp_rd_addr(disp_rd_addr),
        .disp_rd_valid(disp_rd_valid), .disp_rd_data(disp_rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .vblank(vblank), .wr_vblank_only(wr_vblank_only),
        .clr_status(clr_status), .wr_count(wr_count), .wr_starve(wr_starve),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural single-port BRAM, preloaded with addr*3 on its first edge.
    logic [TDW-1:0] bram_mem [NMEM];
    bit             bram_loaded;
    always @(posedge CLK) begin
        if (!bram_loaded) begin
            for (int i = 0; i < NMEM; i++) bram_mem[i] <= TDW'(i * 3);
            bram_loaded <= 1'b1;
        end else if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_din;
            else         bram_dout <= bram_mem[bram_addr];
        end
    end

    typedef struct { logic [TAW-1:0] a; logic [TDW-1:0] d; } wr_t;
    typedef struct { int due; logic [TDW-1:0] d; } rd_t;

    wr_t            wq[$];
    rd_t            rdq[$];
    logic [TDW-1:0] ref_mem [NMEM];
    int             cyc;
    bit             fresh;
    int             run;
    bit             flag;
    logic           exp_en, exp_we;
    logic [TAW-1:0] last_addr;
    logic [TDW-1:0] last_din, last_rd;
    int             n_checks, n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        wq.delete();
        rdq.delete();
        fresh     = 1'b1;
        run       = 0;
        flag      = 1'b0;
        exp_en    = 1'b0;
        exp_we    = 1'b0;
        last_addr = '0;
        last_din  = '0;
        last_rd   = '0;
    endtask

    task automatic check_all();
        chk("bram_en",   bram_en,   exp_en);
        chk("bram_we",   bram_we,   exp_we);
        chk("bram_addr", bram_addr, last_addr);
        chk("bram_din",  bram_din,  last_din);
        chk("wr_count",  wr_count,  wq.size());
        chk("wr_ready",  wr_ready,  !fresh && (wq.size() < TDEPTH));
        chk("wr_starve", wr_starve, flag);
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            chk("rd_valid", disp_rd_valid, 1'b1);
            chk("rd_data",  disp_rd_data,  rdq[0].d);
            last_rd = rdq[0].d;
            void'(rdq.pop_front());
        end else begin
            chk("rd_valid", disp_rd_valid, 1'b0);
            chk("rd_hold",  disp_rd_data,  last_rd);
        end
    endtask

    // Apply the currently driven inputs to the model, clock one edge, compare.
    task automatic step();
        int  pre_size;
        bit  pre_ready;
        bit  popd;
        wr_t e;
        pre_size  = wq.size();
        pre_ready = !fresh && (pre_size < TDEPTH);
        popd      = 1'b0;
        cyc++;
        exp_en = 1'b0;
        exp_we = 1'b0;
        if (disp_rd_req) begin
            exp_en    = 1'b1;
            last_addr = disp_rd_addr;
            rdq.push_back('{cyc + 2, ref_mem[disp_rd_addr]});
        end else if (pre_size > 0 && (!wr_vblank_only || vblank)) begin
            popd      = 1'b1;
            exp_en    = 1'b1;
            exp_we    = 1'b1;
            e         = wq.pop_front();
            ref_mem[e.a] = e.d;
            last_addr = e.a;
            last_din  = e.d;
        end
        if (wr_valid && pre_ready) wq.push_back('{wr_addr, wr_data});
        if (clr_status) begin
            run  = 0;
            flag = 1'b0;
        end else if (pre_size == TDEPTH && !popd) begin
            if (run < TLIM) run++;
            if (run >= TLIM) flag = 1'b1;
        end else begin
            run = 0;
        end
        fresh = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    task automatic idle();
        disp_rd_req    = 1'b0;
        disp_rd_addr   = '0;
        wr_valid       = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        vblank         = 1'b0;
        wr_vblank_only = 1'b0;
        clr_status     = 1'b0;
    endtask

    initial begin
        int p_rd;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        for (int i = 0; i < NMEM; i++) ref_mem[i] = TDW'(i * 3);
        idle();
        model_reset();
        nRESET = 1'b0;
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;
        check_all();

        // Reads only: data = addr*3 after two edges
        for (int i = 0; i < 5; i++) begin
            disp_rd_req = 1'b1; disp_rd_addr = TAW'(i); step();
        end
        idle(); repeat (3) step();

        // Fill the FIFO behind a read stream, then drain and read back
        for (int i = 0; i < 5; i++) begin
            disp_rd_req = 1'b1; disp_rd_addr = TAW'(100 + i);
            wr_valid = 1'b1; wr_addr = TAW'(10 + i); wr_data = TDW'(24'hA0 + i);
            step();
        end
        idle(); repeat (5) step();
        for (int i = 0; i < 4; i++) begin
            disp_rd_req = 1'b1; disp_rd_addr = TAW'(10 + i); step();
        end
        idle(); repeat (3) step();

        // Alternate-cycle reads with two buffered writes
        wr_vblank_only = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_addr = TAW'(20 + i); wr_data = TDW'(24'hB0 + i); step();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            disp_rd_req = (i % 2 == 0); disp_rd_addr = TAW'(20 + i); step();
        end
        idle(); repeat (3) step();

        // vblank gating
        wr_vblank_only = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = TAW'(30 + i); wr_data = TDW'(24'hC0 + i); step();
        end
        wr_valid = 1'b0; repeat (2) step();
        vblank = 1'b1; repeat (4) step();
        idle(); step();

        // Starvation: FIFO full under a constant read stream
        wr_vblank_only = 1'b1; disp_rd_req = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            disp_rd_addr = TAW'(40 + i); wr_addr = TAW'(50 + i); wr_data = TDW'(24'hD0 + i);
            step();
        end
        clr_status = 1'b1; step();
        clr_status = 1'b0;
        repeat (10) step();

        // Async reset with three buffered writes and a read in flight
        wr_valid = 1'b0; disp_rd_req = 1'b0; vblank = 1'b1; step();
        vblank = 1'b0; disp_rd_req = 1'b1; disp_rd_addr = TAW'(7); step();
        #2;
        nRESET = 1'b0;
        model_reset();
        #1;
        check_all();
        idle();
        @(negedge CLK);
        nRESET = 1'b1;
        check_all();
        repeat (4) step();

        // Randomized traffic
        p_rd = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) begin
                p_rd = $urandom_range(10, 95);
                wr_vblank_only = ($urandom_range(0, 2) == 0);
            end
            disp_rd_req  = ($urandom_range(0, 99) < p_rd);
            disp_rd_addr = TAW'($urandom_range(0, 63));
            wr_valid     = ($urandom_range(0, 99) < 60);
            wr_addr      = TAW'($urandom_range(0, 63));
            wr_data      = TDW'($urandom);
            if ($urandom_range(0, 19) == 0) vblank = ~vblank;
            clr_status   = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
